// File: rtl/sram32_arb_pkg.sv
// rtl/sram32_arb_pkg.sv - shared constants and address helper for the SRAM arbiter
package sram32_arb_pkg;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int STARVE_MAX_DEFAULT = 3;
   localparam int CNT_W_DEFAULT      = 4;

   // SRAM word index for a byte address (16K words)
   function automatic logic [13:0] word_addr(input logic [31:0] adr);
      return adr[15:2];
   endfunction

endpackage

// File: rtl/sram32_arb_starve.sv
// rtl/sram32_arb_starve.sv - saturating count of consecutive denied I-request cycles
module sram32_arb_starve #(
   parameter int STARVE_MAX = 3,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sram32_arb.sv
// rtl/sram32_arb.sv - D-priority arbiter sharing one 32-bit SRAM between I-fetch and load/store
module sram32_arb
   import sram32_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_adr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_adr,
   input  logic [31:0] d_din,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_en,
   output logic [3:0]  m_we,
   output logic [31:0] m_adr,
   output logic [31:0] m_din,
   input  logic [31:0] m_dout
);

   logic starve_sat;
   logic resp_i_q, resp_i_d;
   logic resp_d_q, resp_d_d;

   sram32_arb_starve #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (i_req & ~i_gnt),
      .clr (i_gnt | ~i_req),
      .sat (starve_sat)
   );

   // I only beats a concurrent D request once it has waited STARVE_MAX cycles
   assign i_gnt = ~rst & i_req & (~d_req | starve_sat);
   assign d_gnt = ~rst & d_req & ~(i_req & starve_sat);

   assign m_en  = i_gnt | d_gnt;
   assign m_adr = i_gnt ? i_adr : d_adr;
   assign m_we  = d_gnt ? d_we : 4'h0;
   assign m_din = d_din;

   assign resp_i_d = i_gnt;
   assign resp_d_d = d_gnt & (d_we == 4'h0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_i_q <= 1'b0;
         resp_d_q <= 1'b0;
      end else begin
         resp_i_q <= resp_i_d;
         resp_d_q <= resp_d_d;
      end
   end

   // single read bus; the rvalid flops say whose data it is
   assign i_rvalid = resp_i_q;
   assign d_rvalid = resp_d_q;
   assign i_rdata  = m_dout;
   assign d_rdata  = m_dout;

endmodule

// File: tb/tb_sram32_arb.sv
// tb/tb_sram32_arb.sv - self-checking bench for sram32_arb with SRAM and reference models
module tb_sram32_arb;
   import sram32_arb_pkg::*;

   localparam int SMAX = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_adr = '0;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic [3:0]  d_we = '0;
   logic [31:0] d_adr = '0;
   logic [31:0] d_din = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic [3:0]  m_we;
   logic [31:0] m_adr;
   logic [31:0] m_din;
   logic [31:0] m_dout;

   int n_vec = 0;
   int n_err = 0;

   sram32_arb #(.STARVE_MAX(SMAX), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_adr    (i_adr),
      .i_gnt    (i_gnt),
      .i_rvalid (i_rvalid),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_adr    (d_adr),
      .d_din    (d_din),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_en     (m_en),
      .m_we     (m_we),
      .m_adr    (m_adr),
      .m_din    (m_din),
      .m_dout   (m_dout)
   );

   always #5 clk = ~clk;

   // SRAM with one-cycle read latency
   logic [31:0] sram [0:16383];
   logic [31:0] sram_dout = '0;
   assign m_dout = sram_dout;

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (m_we[b]) sram[word_addr(m_adr)][8*b +: 8] <= m_din[8*b +: 8];
         end else begin
            sram_dout <= sram[word_addr(m_adr)];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: golden memory, pending-response record, denied-cycle count
   logic [31:0] ref_mem [0:16383];
   logic        pend_i = 1'b0;
   logic        pend_d = 1'b0;
   logic [31:0] pend_data = '0;
   int          denied = 0;

   initial begin
      for (int w = 0; w < 16384; w++) begin
         sram[w]    = '0;
         ref_mem[w] = '0;
      end
   end

   initial begin : model
      logic        eg_i, eg_d;
      logic        n_pend_i, n_pend_d;
      logic [31:0] n_data;
      int          n_denied;
      logic [31:0] w_adr, w_din;
      logic [3:0]  w_we;
      forever begin
         @(negedge clk);
         if (rst) begin
            eg_i = 1'b0;
            eg_d = 1'b0;
         end else if (i_req && d_req) begin
            eg_i = (denied >= SMAX);
            eg_d = !eg_i;
         end else begin
            eg_i = i_req;
            eg_d = d_req;
         end
         check("i_gnt", 32'(i_gnt), 32'(eg_i));
         check("d_gnt", 32'(d_gnt), 32'(eg_d));
         check("m_en", 32'(m_en), 32'(eg_i | eg_d));
         check("m_we", 32'(m_we), eg_d ? 32'(d_we) : 32'h0);
         check("m_adr", m_adr, eg_i ? i_adr : d_adr);
         check("m_din", m_din, d_din);
         check("i_rvalid", 32'(i_rvalid), 32'(pend_i));
         check("d_rvalid", 32'(d_rvalid), 32'(pend_d));
         if (pend_i) check("i_rdata", i_rdata, pend_data);
         if (pend_d) check("d_rdata", d_rdata, pend_data);

         n_pend_i = eg_i;
         n_pend_d = eg_d && (d_we == 4'h0);
         n_data   = ref_mem[word_addr(eg_i ? i_adr : d_adr)];
         n_denied = (i_req && !eg_i && !rst) ? denied + 1 : 0;
         w_we     = eg_d ? d_we : 4'h0;
         w_adr    = d_adr;
         w_din    = d_din;

         @(posedge clk);
         if (rst) begin
            pend_i = 1'b0;
            pend_d = 1'b0;
            denied = 0;
         end else begin
            pend_i    = n_pend_i;
            pend_d    = n_pend_d;
            pend_data = n_data;
            denied    = n_denied;
            for (int b = 0; b < 4; b++)
               if (w_we[b]) ref_mem[word_addr(w_adr)][8*b +: 8] = w_din[8*b +: 8];
         end
      end
   end

   task automatic d_op(input logic [3:0] we, input logic [31:0] adr, input logic [31:0] din);
      d_req = 1'b1;
      d_we  = we;
      d_adr = adr;
      d_din = din;
      @(posedge clk); #1;
   endtask

   task automatic contend(input int n, output logic [15:0] seq);
      seq   = '0;
      i_req = 1'b1;
      i_adr = 32'h80;
      d_req = 1'b1;
      d_we  = 4'h0;
      d_adr = 32'h40;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         seq = {seq[14:0], i_gnt};
         @(posedge clk); #1;
      end
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   initial begin : stim
      logic [15:0] seq;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // idle after reset
      repeat (10) begin
         @(negedge clk);
         check("idle_m_en", 32'(m_en), 32'h0);
         check("idle_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
      end
      @(posedge clk); #1;

      // full-word write then read back
      d_op(4'hF, 32'h40, 32'hDEADBEEF);
      d_op(4'h0, 32'h40, 32'h0);
      d_req = 1'b0;
      @(negedge clk);
      check("wr_rd_rvalid", 32'(d_rvalid), 32'h1);
      check("wr_rd_data", d_rdata, 32'hDEADBEEF);
      check("wr_rd_no_i", 32'(i_rvalid), 32'h0);
      @(posedge clk); #1;

      // byte-lane merge
      d_op(4'hF, 32'h80, 32'h11223344);
      d_op(4'b0100, 32'h80, 32'h00AA0000);
      d_op(4'h0, 32'h80, 32'h0);
      d_req = 1'b0;
      @(negedge clk);
      check("byte_wr_data", d_rdata, 32'h11AA3344);
      @(posedge clk); #1;

      // contention: D x3 then I, repeating
      contend(12, seq);
      check("contend_seq", 32'(seq[11:0]), 32'h111);
      @(posedge clk); #1;

      // interleaved I and D reads with distinct data
      d_op(4'hF, 32'h0, 32'hA5A50000);
      d_op(4'hF, 32'h4, 32'h5A5A1111);
      d_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         i_req = (k % 2 == 0);
         i_adr = 32'h0;
         d_req = (k % 2 == 1);
         d_we  = 4'h0;
         d_adr = 32'h4;
         @(posedge clk); #1;
         i_req = 1'b0;
         d_req = 1'b0;
         @(negedge clk);
         if (k % 2 == 0) check("ilv_i_data", i_rdata, 32'hA5A50000);
         else            check("ilv_d_data", d_rdata, 32'h5A5A1111);
         @(posedge clk); #1;
      end

      // reset lands between a D read grant and its response edge
      d_op(4'h0, 32'h40, 32'h0);
      d_req = 1'b1;
      d_we  = 4'h0;
      d_adr = 32'h40;
      i_req = 1'b1;
      i_adr = 32'h80;
      @(negedge clk);
      check("rst_pre_gnt", 32'(d_gnt), 32'h1);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      d_req = 1'b0;
      i_req = 1'b0;
      @(negedge clk);
      check("rst_no_rvalid", 32'(d_rvalid), 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // counter restarts from zero after reset
      contend(4, seq);
      check("post_rst_seq", 32'(seq[3:0]), 32'h1);
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
